// File: rtl/sar_pkg.sv
// Shared types and elaboration helpers for the SAR ADC controller.
package sar_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAMPLE,
        S_TRIAL,
        S_DECIDE,
        S_DONE
    } sar_state_e;

    localparam int OVERSAMPLE_LOG2 = 2;

    // Each bit needs the synchronizer to have flushed the new comparator level before DECIDE.
    function automatic bit settle_cycles_ok(input int settle, input int stages);
        return settle >= stages + 1;
    endfunction

endpackage

// File: rtl/sar_sync.sv
// Multi-flop synchronizer bringing the asynchronous comparator level into clk.
module sar_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic sync_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[STAGES-2:0], async_i};
    end

    assign sync_o = sync_q[STAGES-1];

endmodule

// File: rtl/sar_adc_ctrl.sv
// SAR ADC controller: track/hold, MSB-first binary search, valid/ready result.
// Define SAR_OVERSAMPLE_EN to average four back-to-back conversions per request.
module sar_adc_ctrl
    import sar_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int SAMPLE_CYCLES = 8,
    parameter int SETTLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             sample_o,
    output logic [WIDTH-1:0] dac_code,
    input  logic             cmp_in,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    input  logic             result_ready
);

    localparam int CNT_MAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int KW      = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] SAMPLE_LOAD = CNT_W'(SAMPLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [KW-1:0]    MSB_IDX     = KW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MSB_ONE     = {1'b1, {(WIDTH-1){1'b0}}};

    generate
        if (!settle_cycles_ok(SETTLE_CYCLES, SYNC_STAGES)) begin : g_bad_settle
            $error("SETTLE_CYCLES must be at least SYNC_STAGES+1");
        end
    endgenerate

    sar_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [KW-1:0]    bit_q;
    logic [WIDTH-1:0] dac_code_q, result_q, trial_d;
    logic             busy_q, sample_q, valid_q;
    logic             cmp_sync;

`ifdef SAR_OVERSAMPLE_EN
    localparam int ACC_W = WIDTH + OVERSAMPLE_LOG2;
    logic [ACC_W-1:0]           acc_q, acc_sum;
    logic [OVERSAMPLE_LOG2-1:0] conv_q;

    assign acc_sum = acc_q + {{OVERSAMPLE_LOG2{1'b0}}, trial_d};
`endif

    sar_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .rst    (rst),
        .async_i(cmp_in),
        .sync_o (cmp_sync)
    );

    // Resolve the bit under test and, if more remain, raise the next trial bit.
    always_comb begin
        trial_d = dac_code_q;
        if (!cmp_sync) trial_d[bit_q] = 1'b0;
        if (bit_q != '0) trial_d[bit_q - 1'b1] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            dac_code_q <= '0;
            result_q   <= '0;
            busy_q     <= 1'b0;
            sample_q   <= 1'b0;
            valid_q    <= 1'b0;
`ifdef SAR_OVERSAMPLE_EN
            acc_q      <= '0;
            conv_q     <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    state_q    <= S_SAMPLE;
                    busy_q     <= 1'b1;
                    sample_q   <= 1'b1;
                    dac_code_q <= '0;
                    cnt_q      <= SAMPLE_LOAD;
                end
                S_SAMPLE: if (cnt_q == '0) begin
                    state_q    <= S_TRIAL;
                    sample_q   <= 1'b0;
                    bit_q      <= MSB_IDX;
                    dac_code_q <= MSB_ONE;
                    cnt_q      <= SETTLE_LOAD;
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                end
                S_TRIAL: if (cnt_q == '0) state_q <= S_DECIDE;
                         else             cnt_q   <= cnt_q - 1'b1;
                S_DECIDE: begin
                    dac_code_q <= trial_d;
                    if (bit_q != '0) begin
                        bit_q   <= bit_q - 1'b1;
                        cnt_q   <= SETTLE_LOAD;
                        state_q <= S_TRIAL;
                    end else begin
`ifdef SAR_OVERSAMPLE_EN
                        if (&conv_q) begin
                            result_q <= acc_sum[ACC_W-1:OVERSAMPLE_LOG2];
                            acc_q    <= '0;
                            conv_q   <= '0;
                            valid_q  <= 1'b1;
                            busy_q   <= 1'b0;
                            state_q  <= S_DONE;
                        end else begin
                            acc_q      <= acc_sum;
                            conv_q     <= conv_q + 1'b1;
                            sample_q   <= 1'b1;
                            dac_code_q <= '0;
                            cnt_q      <= SAMPLE_LOAD;
                            state_q    <= S_SAMPLE;
                        end
`else
                        result_q <= trial_d;
                        valid_q  <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= S_DONE;
`endif
                    end
                end
                S_DONE: if (result_ready) begin
                    valid_q    <= 1'b0;
                    dac_code_q <= '0;
                    state_q    <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy         = busy_q;
    assign sample_o     = sample_q;
    assign dac_code     = dac_code_q;
    assign result       = result_q;
    assign result_valid = valid_q;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Directed bench for sar_adc_ctrl with an ideal comparator (vin >= dac_code).
module tb_sar_adc_ctrl;

`ifdef SAR_OVERSAMPLE_EN
    localparam int LAT = 192;
`else
    localparam int LAT = 48;
`endif

    logic       clk = 1'b0, rst = 1'b1, start = 1'b0, result_ready = 1'b0;
    logic       busy, sample_o, cmp_in, result_valid;
    logic [7:0] dac_code, result;
    logic [7:0] vin = 8'h00, os_vin = 8'h40, vin_cmp;
    logic       os_mode = 1'b0, os_tog = 1'b0;
    int         checks = 0, failures = 0, cyc = 0, t0 = 0;

    sar_adc_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .sample_o    (sample_o),
        .dac_code    (dac_code),
        .cmp_in      (cmp_in),
        .result      (result),
        .result_valid(result_valid),
        .result_ready(result_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    assign vin_cmp = os_mode ? os_vin : vin;
    assign cmp_in  = (vin_cmp >= dac_code);

    // Input alternates 0x40 / 0x43 at the start of each track phase.
    always @(posedge sample_o) begin
        os_vin = os_tog ? 8'h43 : 8'h40;
        os_tog = ~os_tog;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (result_valid !== 1'b1 && n < 1000) begin
            step(1);
            n++;
        end
        check({tag, "_latency"}, cyc - t0, LAT);
        check({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic handshake(input string tag);
        result_ready = 1'b1;
        step(1);
        result_ready = 1'b0;
        check({tag, "_valid_drop"}, {31'd0, result_valid}, 32'd0);
        check({tag, "_dac_clear"}, {24'd0, dac_code}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        step(3);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_sample", {31'd0, sample_o}, 32'd0);
        check("rst_dac", {24'd0, dac_code}, 32'd0);
        check("rst_result", {24'd0, result}, 32'd0);
        check("rst_valid", {31'd0, result_valid}, 32'd0);
        rst = 1'b0;
        step(1);

        vin = 8'hA5;
        do_start();
        check("a5_busy", {31'd0, busy}, 32'd1);
        check("a5_sample", {31'd0, sample_o}, 32'd1);
        check("a5_dac0", {24'd0, dac_code}, 32'd0);
        wait_valid("a5");
        check("a5_result", {24'd0, result}, 32'hA5);
        handshake("a5");

        vin = 8'h00;
        do_start();
        step(7);
        check("z_sample_hold", {31'd0, sample_o}, 32'd1);
        step(1);
        check("z_sample_end", {31'd0, sample_o}, 32'd0);
        check("z_dac_msb", {24'd0, dac_code}, 32'h80);
        step(5);
        check("z_dac_bit6", {24'd0, dac_code}, 32'h40);
        wait_valid("z");
        check("z_result", {24'd0, result}, 32'h00);
        handshake("z");

        vin = 8'hFF;
        do_start();
        step(8);
        check("f_dac_msb", {24'd0, dac_code}, 32'h80);
        step(5);
        check("f_dac_bit6", {24'd0, dac_code}, 32'hC0);
        wait_valid("f");
        check("f_result", {24'd0, result}, 32'hFF);
        handshake("f");

        // Consumer stalls; a start pulse and an input change must not disturb the held result.
        vin = 8'h5A;
        do_start();
        wait_valid("hold");
        for (int i = 0; i < 10; i++) begin
            if (i == 0) vin = 8'h11;
            start = (i == 3);
            step(1);
        end
        start = 1'b0;
        check("hold_result", {24'd0, result}, 32'h5A);
        check("hold_valid", {31'd0, result_valid}, 32'd1);
        check("hold_busy", {31'd0, busy}, 32'd0);
        handshake("hold");
        step(2);
        check("hold_no_queue", {31'd0, busy}, 32'd0);

        vin = 8'hA5;
        do_start();
        step(19);
        rst = 1'b1;
        step(1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_dac", {24'd0, dac_code}, 32'd0);
        check("abort_sample", {31'd0, sample_o}, 32'd0);
        check("abort_valid", {31'd0, result_valid}, 32'd0);
        rst = 1'b0;
        step(1);
        vin = 8'h3C;
        do_start();
        wait_valid("post_abort");
        check("post_abort_result", {24'd0, result}, 32'h3C);
        handshake("post_abort");

        vin = 8'h81;
        do_start();
        step(4);
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(24);
        start = 1'b1;
        step(1);
        start = 1'b0;
        wait_valid("dup");
        check("dup_result", {24'd0, result}, 32'h81);
        handshake("dup");

        vin = 8'h01;
        do_start();
        check("b2b_busy", {31'd0, busy}, 32'd1);
        wait_valid("b2b");
        check("b2b_result", {24'd0, result}, 32'h01);
        handshake("b2b");
        step(3);
        check("b2b_idle", {31'd0, busy}, 32'd0);

`ifdef SAR_OVERSAMPLE_EN
        os_tog  = 1'b0;
        os_mode = 1'b1;
        do_start();
        wait_valid("os");
        check("os_result", {24'd0, result}, 32'h41);
        handshake("os");
        os_mode = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
